// File: rtl/apb_pkg.sv
// Shared types for the APB initiator: FSM state encoding and the queued command word.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package apb_pkg;

   localparam int AMBA_WORD_P       = 32;
   localparam int AMBA_ADDR_WIDTH_P = 20;

   typedef enum logic [1:0] {
      APB_IDLE   = 2'd0,
      APB_SETUP  = 2'd1,
      APB_ACCESS = 2'd2
   } apb_state_t;

   typedef struct packed {
      logic                         write;
      logic [AMBA_ADDR_WIDTH_P-1:0] addr;
      logic [AMBA_WORD_P-1:0]       wdata;
   } apb_cmd_t;

   // Bundles the command-port fields into one queue word.
   function automatic apb_cmd_t apb_make_cmd(input logic                         write,
                                             input logic [AMBA_ADDR_WIDTH_P-1:0] addr,
                                             input logic [AMBA_WORD_P-1:0]       wdata);
      apb_cmd_t c;
      c.write = write;
      c.addr  = addr;
      c.wdata = wdata;
      return c;
   endfunction

endpackage

// File: rtl/apb_cmd_fifo.sv
// Synchronous command queue of apb_cmd_t; the head entry is visible on pop_dat while not empty.
// Latency: a pushed entry is visible at the head one cycle after the push edge.
// Backpressure: push ignored while full (a same-cycle pop does not make room); pop ignored while empty.
module apb_cmd_fifo
   import apb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     push,
   input  apb_cmd_t push_dat,
   input  logic     pop,
   output apb_cmd_t pop_dat,
   output logic     full,
   output logic     empty
);

   localparam int AW    = $clog2(DEPTH);
   localparam int PTR_W = AW + 1;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   apb_cmd_t         mem_q [DEPTH];
   logic             push_ok;
   logic             pop_ok;

   // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign pop_dat = mem_q[rd_ptr_q[AW-1:0]];

   // Pointer advance; pointers wrap naturally through the extra MSB.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
   end

   // Pointer registers; reset flushes the queue.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
   end

endmodule

// File: rtl/apb_master.sv
// APB initiator: executes queued read/write commands as SETUP->ACCESS transfers, returns a response pulse.
// Latency: push at edge N -> SETUP after N+1, ACCESS after N+2, rsp_valid after N+3; one transfer per 2 cycles.
// Backpressure: cmd_ready = !full from registered state only; responses have no backpressure.
// Optional: APB_MASTER_PREADY_EN adds a PREADY input that stretches ACCESS while low.
module apb_master
   import apb_pkg::*;
#(
   parameter int AMBA_WORD       = AMBA_WORD_P,        // must match the package width of apb_cmd_t
   parameter int AMBA_ADDR_WIDTH = AMBA_ADDR_WIDTH_P,  // must match the package width of apb_cmd_t
   parameter int CMD_DEPTH       = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic                       cmd_write,
   input  logic [AMBA_ADDR_WIDTH-1:0] cmd_addr,
   input  logic [AMBA_WORD-1:0]       cmd_wdata,
   output logic                       rsp_valid,
   output logic                       rsp_write,
   output logic [AMBA_WORD-1:0]       rsp_rdata,
   output logic                       busy,
   output logic                       PSEL,
   output logic                       PENABLE,
   output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
   output logic                       PWRITE,
   output logic [AMBA_WORD-1:0]       PWDATA,
`ifdef APB_MASTER_PREADY_EN
   input  logic                       PREADY,
`endif
   input  logic [AMBA_WORD-1:0]       PRDATA
);

   apb_state_t                 state_q, state_d;
   apb_cmd_t                   fifo_push_dat;
   apb_cmd_t                   fifo_head;
   logic                       fifo_push;
   logic                       fifo_pop;
   logic                       fifo_full;
   logic                       fifo_empty;
   logic                       ready_en_q, ready_en_d;
   logic [AMBA_ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic                       pwrite_q, pwrite_d;
   logic [AMBA_WORD-1:0]       pwdata_q, pwdata_d;
   logic                       rsp_valid_q, rsp_valid_d;
   logic                       rsp_write_q, rsp_write_d;
   logic [AMBA_WORD-1:0]       rsp_rdata_q, rsp_rdata_d;
   logic                       pready;
   logic                       xfer_done;
   logic                       load_cmd;

`ifdef APB_MASTER_PREADY_EN
   assign pready = PREADY;
`else
   assign pready = 1'b1;
`endif

   // ready_en_q keeps cmd_ready low during reset and raises it on the first edge after release.
   assign cmd_ready     = ready_en_q && !fifo_full;
   assign fifo_push     = cmd_valid && cmd_ready;
   assign fifo_push_dat = apb_make_cmd(cmd_write, cmd_addr, cmd_wdata);
   assign xfer_done     = (state_q == APB_ACCESS) && pready;
   assign load_cmd      = !fifo_empty && ((state_q == APB_IDLE) || xfer_done);
   assign busy          = !fifo_empty || (state_q != APB_IDLE);

   apb_cmd_fifo #(
      .DEPTH    (CMD_DEPTH)
   ) u_cmd_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (fifo_push),
      .push_dat (fifo_push_dat),
      .pop      (fifo_pop),
      .pop_dat  (fifo_head),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   // State register; reset drops PSEL/PENABLE immediately and abandons any transfer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= APB_IDLE;
      else     state_q <= state_d;
   end

   // Next state: ACCESS chains straight into SETUP when more work is queued.
   always_comb begin
      state_d = state_q;
      case (state_q)
         APB_IDLE:   if (!fifo_empty) state_d = APB_SETUP;
         APB_SETUP:  state_d = APB_ACCESS;
         APB_ACCESS: if (pready) state_d = fifo_empty ? APB_IDLE : APB_SETUP;
         default:    state_d = APB_IDLE;
      endcase
   end

   // Outputs and datapath: pop/load the head on entry to SETUP, capture the response on completion.
   always_comb begin
      PSEL        = (state_q != APB_IDLE);
      PENABLE     = (state_q == APB_ACCESS);
      ready_en_d  = 1'b1;
      fifo_pop    = 1'b0;
      paddr_d     = paddr_q;
      pwrite_d    = pwrite_q;
      pwdata_d    = pwdata_q;
      rsp_valid_d = 1'b0;
      rsp_write_d = rsp_write_q;
      rsp_rdata_d = rsp_rdata_q;
      if (load_cmd) begin
         fifo_pop = 1'b1;
         paddr_d  = fifo_head.addr;
         pwrite_d = fifo_head.write;
         pwdata_d = fifo_head.wdata;
      end
      if (xfer_done) begin
         rsp_valid_d = 1'b1;
         rsp_write_d = pwrite_q;
         rsp_rdata_d = pwrite_q ? '0 : PRDATA;
      end
   end

   // Bus-side and response registers; APB address/data hold their last value in IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ready_en_q  <= 1'b0;
         paddr_q     <= '0;
         pwrite_q    <= 1'b0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         ready_en_q  <= ready_en_d;
         paddr_q     <= paddr_d;
         pwrite_q    <= pwrite_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_write_q <= rsp_write_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign PADDR     = paddr_q;
   assign PWRITE    = pwrite_q;
   assign PWDATA    = pwdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_write = rsp_write_q;
   assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed latency/ordering/reset scenarios plus random traffic,
// checked by a scoreboard against a memory-map model and an APB protocol monitor.
module tb_apb_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_write = 1'b0;
   logic [19:0] cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic        rsp_valid;
   logic        rsp_write;
   logic [31:0] rsp_rdata;
   logic        busy;
   logic        PSEL;
   logic        PENABLE;
   logic [19:0] PADDR;
   logic        PWRITE;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA = '0;
   logic        pready_s;
`ifdef APB_MASTER_PREADY_EN
   logic        PREADY = 1'b1;
   int          pready_mode = 1;   // 0 random, 1 forced high, 2 driven by the main sequence
   assign pready_s = PREADY;
`else
   assign pready_s = 1'b1;
`endif

   apb_master #(
      .AMBA_WORD       (32),
      .AMBA_ADDR_WIDTH (20),
      .CMD_DEPTH       (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_write (rsp_write),
      .rsp_rdata (rsp_rdata),
      .busy      (busy),
      .PSEL      (PSEL),
      .PENABLE   (PENABLE),
      .PADDR     (PADDR),
      .PWRITE    (PWRITE),
      .PWDATA    (PWDATA),
`ifdef APB_MASTER_PREADY_EN
      .PREADY    (PREADY),
`endif
      .PRDATA    (PRDATA)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        w;
      logic [19:0] a;
      logic [31:0] d;
   } cmd_s;
   typedef struct {
      logic        w;
      logic [31:0] r;
   } rsp_s;

   int          checks = 0;
   int          errors = 0;
   cmd_s        issue_q[$];
   rsp_s        exp_q[$];
   bit   [31:0] model_mem [bit [19:0]];
   bit   [31:0] slv_mem   [bit [19:0]];
   logic [19:0] pool [8];
   logic        stall_at_edge = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a register map updated in command order. A read expects whatever
   // the most recent earlier write to that address left there.
   task automatic model_push(input logic w, input logic [19:0] a, input logic [31:0] d);
      cmd_s c;
      rsp_s e;
      c.w = w; c.a = a; c.d = d;
      issue_q.push_back(c);
      e.w = w;
      if (w) begin
         model_mem[a] = d;
         e.r = 32'h0;
      end else begin
         e.r = model_mem.exists(a) ? model_mem[a] : 32'h0;
      end
      exp_q.push_back(e);
   endtask

   // APB slave: commits writes on the completing edge, presents read data during ACCESS
   // and garbage otherwise so mistimed capture is visible.
   always @(posedge clk) begin
      if (!rst && PSEL && PENABLE && pready_s && PWRITE) slv_mem[PADDR] = PWDATA;
      stall_at_edge = !rst && PSEL && PENABLE && !pready_s;
   end

   always @(negedge clk) begin
`ifdef APB_MASTER_PREADY_EN
      if (pready_mode == 0)      PREADY = ($urandom_range(0, 2) != 0);
      else if (pready_mode == 1) PREADY = 1'b1;
`endif
      if (PSEL && PENABLE && !PWRITE) PRDATA = slv_mem.exists(PADDR) ? slv_mem[PADDR] : 32'h0;
      else                            PRDATA = $urandom;
   end

   // Monitor: response scoreboard plus APB protocol/order checks.
   logic        prev_psel = 0, prev_pen = 0, prev_rsp = 0, prev_pw = 0;
   logic [19:0] prev_addr = '0;
   logic [31:0] prev_wd = '0;
   cmd_s        mon_c;
   rsp_s        mon_e;

   always @(negedge clk) begin
      if (rst) begin
         prev_psel = 0; prev_pen = 0; prev_rsp = 0; prev_pw = 0; prev_addr = '0; prev_wd = '0;
      end else begin
         if (rsp_valid) begin
            chk("rsp_not_consecutive", prev_rsp, 1'b0);
            chk("rsp_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
               mon_e = exp_q.pop_front();
               chk("rsp_write", rsp_write, mon_e.w);
               chk("rsp_rdata", rsp_rdata, mon_e.r);
            end
         end
         if (PENABLE) chk("penable_needs_psel", PSEL, 1'b1);
         if (PSEL && !PENABLE) begin
            chk("setup_expected", issue_q.size() != 0, 1'b1);
            if (issue_q.size() != 0) begin
               mon_c = issue_q.pop_front();
               chk("setup_paddr", PADDR, mon_c.a);
               chk("setup_pwrite", PWRITE, mon_c.w);
               if (mon_c.w) chk("setup_pwdata", PWDATA, mon_c.d);
            end
         end
         if (prev_psel && (!prev_pen || stall_at_edge)) begin
            chk("access_follows", {PSEL, PENABLE}, 2'b11);
            chk("access_paddr_stable", PADDR, prev_addr);
            chk("access_pwrite_stable", PWRITE, prev_pw);
            chk("access_pwdata_stable", PWDATA, prev_wd);
         end
         if (!PSEL) begin
            chk("idle_paddr_hold", PADDR, prev_addr);
            chk("idle_pwdata_hold", PWDATA, prev_wd);
         end
         prev_psel = PSEL; prev_pen = PENABLE; prev_rsp = rsp_valid;
         prev_addr = PADDR; prev_pw = PWRITE; prev_wd = PWDATA;
      end
   end

   // Offers one command starting at a negedge; returns at the negedge after acceptance.
   task automatic send(input logic w, input logic [19:0] a, input logic [31:0] d);
      int n = 0;
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
      while (!cmd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("push_within_bound", n < 100, 1'b1);
      if (n < 100) model_push(w, a, d);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("drain_within_bound", n < 1000, 1'b1);
      @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
   endtask

   task automatic wait_access();
      int n = 0;
      while (!(PSEL && PENABLE) && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("access_within_bound", n < 50, 1'b1);
   endtask

   // Single command into an idle block with exact cycle timing.
   task automatic lat_test(input logic w, input logic [19:0] a, input logic [31:0] d,
                           input logic [31:0] exp_r);
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
      chk("lat_ready", cmd_ready, 1'b1);
      model_push(w, a, d);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("lat_still_idle", {PSEL, PENABLE}, 2'b00);
      @(negedge clk);
      chk("lat_setup", {PSEL, PENABLE}, 2'b10);
      chk("lat_setup_paddr", PADDR, a);
      chk("lat_setup_pwrite", PWRITE, w);
      if (w) chk("lat_setup_pwdata", PWDATA, d);
      @(negedge clk);
      chk("lat_access", {PSEL, PENABLE}, 2'b11);
      chk("lat_access_no_rsp", rsp_valid, 1'b0);
      @(negedge clk);
      chk("lat_rsp_valid", rsp_valid, 1'b1);
      chk("lat_rsp_write", rsp_write, w);
      chk("lat_rsp_rdata", rsp_rdata, exp_r);
      @(negedge clk);
      chk("lat_rsp_pulse", rsp_valid, 1'b0);
   endtask

   initial begin
      logic        saw_not_ready;
      logic        b2b_psel [12];
      logic        b2b_pen  [12];
      logic        b2b_rv   [12];
      logic [31:0] d;
      foreach (pool[i]) pool[i] = 20'($urandom) & 20'hFFFFC;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_psel_penable", {PSEL, PENABLE}, 2'b00);
      chk("rst_paddr", PADDR, 20'h0);
      chk("rst_pwrite_pwdata", {PWRITE, PWDATA}, 33'h0);
      chk("rst_rsp", {rsp_valid, rsp_write, rsp_rdata}, 34'h0);
      chk("rst_busy_ready", {busy, cmd_ready}, 2'b00);
      rst = 1'b0;
      chk("ready_low_before_edge", cmd_ready, 1'b0);
      @(negedge clk);
      chk("ready_after_release", cmd_ready, 1'b1);

      // Single write, then single read of preloaded data
      lat_test(1'b1, 20'h00004, 32'hDEADBEEF, 32'h0);
      slv_mem[20'h00008] = 32'h0000001A;
      model_mem[20'h00008] = 32'h0000001A;
      lat_test(1'b0, 20'h00008, 32'h12345678, 32'h0000001A);

      // Back-to-back: four register writes on consecutive cycles
      for (int i = 0; i < 12; i++) begin
         b2b_psel[i] = PSEL; b2b_pen[i] = PENABLE; b2b_rv[i] = rsp_valid;
         if (i < 4) begin
            d = $urandom;
            cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 20'(i * 4); cmd_wdata = d;
            chk("b2b_ready", cmd_ready, 1'b1);
            model_push(1'b1, 20'(i * 4), d);
         end else begin
            cmd_valid = 1'b0;
         end
         @(negedge clk);
      end
      for (int i = 2; i < 10; i++) begin
         chk("b2b_psel_held", b2b_psel[i], 1'b1);
         chk("b2b_penable_toggle", b2b_pen[i], (i % 2 == 1));
      end
      chk("b2b_psel_drop", b2b_psel[10], 1'b0);
      for (int i = 1; i < 12; i++)
         chk("b2b_rsp_spacing", b2b_rv[i], (i == 4 || i == 6 || i == 8 || i == 10));
      wait_idle();

      // Full FIFO: cmd_valid held for 10 cycles
      saw_not_ready = 1'b0;
      cmd_write = $urandom_range(0, 1); cmd_addr = pool[$urandom_range(0, 7)]; cmd_wdata = $urandom;
      for (int i = 0; i < 10; i++) begin
         cmd_valid = 1'b1;
         if (cmd_ready) begin
            model_push(cmd_write, cmd_addr, cmd_wdata);
            @(negedge clk);
            cmd_write = $urandom_range(0, 1); cmd_addr = pool[$urandom_range(0, 7)]; cmd_wdata = $urandom;
         end else begin
            saw_not_ready = 1'b1;
            @(negedge clk);
         end
      end
      cmd_valid = 1'b0;
      chk("full_ready_dropped", saw_not_ready, 1'b1);
      wait_idle();

      // Random traffic
`ifdef APB_MASTER_PREADY_EN
      pready_mode = 0;
`endif
      for (int i = 0; i < 150; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         send($urandom_range(0, 1), pool[$urandom_range(0, 7)], $urandom);
      end
      wait_idle();
      chk("issue_order_drained", issue_q.size(), 0);

`ifdef APB_MASTER_PREADY_EN
      // Wait states: PREADY low for 3 ACCESS cycles, then high
      begin
         logic [19:0] a0;
         pready_mode = 2;
         PREADY = 1'b0;
         send(1'b0, pool[0], 32'h0);
         wait_access();
         a0 = PADDR;
         for (int i = 0; i < 4; i++) begin
            chk("stall_access", {PSEL, PENABLE}, 2'b11);
            chk("stall_paddr", PADDR, a0);
            chk("stall_no_rsp", rsp_valid, 1'b0);
            if (i == 3) PREADY = 1'b1;
            @(negedge clk);
         end
         chk("stall_rsp_once", rsp_valid, 1'b1);
         @(negedge clk);
         chk("stall_rsp_pulse", rsp_valid, 1'b0);
         pready_mode = 1;
         wait_idle();
      end
`endif

      // Reset during ACCESS with two commands queued
      send(1'b1, pool[1], $urandom);
      send(1'b1, pool[2], $urandom);
      send(1'b0, pool[3], 32'h0);
      wait_access();
      rst = 1'b1;
      #1;
      chk("mid_rst_psel_penable", {PSEL, PENABLE}, 2'b00);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_rsp", rsp_valid, 1'b0);
      exp_q.delete(); issue_q.delete(); model_mem.delete(); slv_mem.delete();
      repeat (2) begin
         @(negedge clk);
         chk("mid_rst_hold_rsp", rsp_valid, 1'b0);
      end
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_idle", {busy, rsp_valid, PSEL}, 3'b000);
      chk("post_rst_ready", cmd_ready, 1'b1);
      lat_test(1'b0, pool[1], 32'h0, 32'h0);
      wait_idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
